exe_muldiv_unit: RTL and testbench
==================================

// Module: exe_muldiv_unit
// PURPOSE
//  EXE-side consumer of the ID/EX pipeline register outputs (Val1, Val2, EXE_cmd, dest, WB_en).
//  Executes multi-cycle unsigned MUL/DIV/REM commands iteratively.
//  Drives stall back toward the ID/EX register and upstream stages; the top level ties ID/EX en = ~stall.
//  Delivers a one-cycle result pulse with its dest/WB_en for the EXE/MEM register.
// PARAMETERS
//  WIDTH    32       operand/result width
//  CMD_MUL  4'b1100  EXE_cmd code: low WIDTH bits of Val1*Val2
//  CMD_DIV  4'b1101  EXE_cmd code: Val1/Val2, unsigned quotient
//  CMD_REM  4'b1110  EXE_cmd code: Val1%Val2, unsigned remainder
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      ID/EX holds a live instruction this cycle
//  EXE_cmd    in   4      command from ID/EX
//  Val1       in   WIDTH  operand A / dividend
//  Val2       in   WIDTH  operand B / divisor
//  dest       in   5      destination register
//  WB_en      in   1      write-back enable of the instruction
//  flush      in   1      pipeline flush (taken branch); aborts the current op
//  stall      out  1      hold ID/EX and earlier stages (combinational)
//  res_valid  out  1      one-cycle pulse: res/res_dest/res_WB_en are valid
//  res        out  WIDTH  result
//  res_dest   out  5      dest of the completed op
//  res_WB_en  out  1      WB_en of the completed op
// BEHAVIOUR
//  States: IDLE, BUSY, DONE. rst -> IDLE; count=0; all outputs 0; internal A/B/acc regs 0.
//  start = in_valid & ~flush & (EXE_cmd in {CMD_MUL,CMD_DIV,CMD_REM}) & state==IDLE.
//  Other commands are ignored: no stall, state unchanged.
//  stall = start | (state==BUSY). It is low in DONE, so ID/EX advances on the result cycle.
//  IDLE, start:
//   - latch operands, cmd, dest, WB_en; count <= 0.
//   - If cmd!=MUL and Val2==0: -> DONE directly. DIV gives all-ones; REM gives Val1.
//   - Otherwise -> BUSY.
//  BUSY: one iteration per cycle; count increments.
//   - MUL: shift-add, LSB-first over B.
//   - DIV/REM: restoring, one quotient bit per cycle, MSB first.
//   - After iteration WIDTH-1 (count==WIDTH-1) -> DONE.
//  DONE: res_valid=1 for exactly one cycle, with res and the latched dest/WB_en; -> IDLE.
//   - A new start is not accepted in DONE; it is accepted in the following IDLE cycle.
//  Latency: start at cycle T; res_valid at cycle T+WIDTH+1 (T+1 for divide-by-zero).
//   - Stall covers T..T+WIDTH inclusive.
//  res/res_dest/res_WB_en keep their last values when res_valid=0. res_valid alone qualifies them.
//  MUL drops bits above WIDTH. No overflow flag.
//  flush in BUSY: -> IDLE next edge, no res_valid, stall drops the same cycle (combinational).
//  flush in DONE: the result still issues (the instruction is already committed to EXE).
//  flush with start-eligible input in IDLE: flush wins, nothing is accepted.
//  rst mid-op: immediate return to IDLE, outputs 0, no pulse after release.
// TESTING
//  MUL: Val1=7, Val2=6 -> stall high 33 cycles; res=42, res_valid 1 cycle at T+33, res_dest=dest.
//  MUL wrap: 0xFFFFFFFF*2 -> res=0xFFFFFFFE.
//  DIV 100/7 -> res=14. REM 100/7 -> res=2. Both at T+33.
//  DIV by zero: Val1=5, Val2=0 -> res=0xFFFFFFFF at T+1. REM by zero -> res=5. Stall 1 cycle.
//  flush at BUSY count=10 -> stall low the same cycle; no res_valid; the next MUL 3*3 gives res=9.
//  Non-muldiv EXE_cmd=4'b0000 with in_valid=1 -> stall=0, res_valid=0, state IDLE.
//  rst pulse mid-DIV -> all outputs 0 asynchronously; no pulse after release.
//  Back-to-back MULs (in_valid held) -> second start on the cycle after DONE; two pulses 34 cycles apart.

Source files
------------

// File: rtl/exe_muldiv_unit_if.sv
// ID/EX-side request and EXE/MEM-side result signals of the iterative MUL/DIV/REM unit.
// The pipeline drives the request through master; the unit uses slave.
interface exe_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic [3:0]       EXE_cmd;
    logic [WIDTH-1:0] Val1;
    logic [WIDTH-1:0] Val2;
    logic [4:0]       dest;
    logic             WB_en;
    logic             flush;
    logic             stall;
    logic             res_valid;
    logic [WIDTH-1:0] res;
    logic [4:0]       res_dest;
    logic             res_WB_en;

    modport master (
        output in_valid, EXE_cmd, Val1, Val2, dest, WB_en, flush,
        input  stall, res_valid, res, res_dest, res_WB_en
    );

    modport slave (
        input  in_valid, EXE_cmd, Val1, Val2, dest, WB_en, flush,
        output stall, res_valid, res, res_dest, res_WB_en
    );
endinterface

// File: rtl/exe_muldiv_unit.sv
// Iterative unsigned MUL/DIV/REM for the EXE stage: one bit per cycle, stalls ID/EX while busy,
// and emits a one-cycle result pulse carrying dest/WB_en.
module exe_muldiv_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter logic [3:0]  CMD_MUL = 4'b1100,
    parameter logic [3:0]  CMD_DIV = 4'b1101,
    parameter logic [3:0]  CMD_REM = 4'b1110
) (
    input logic              clk,
    input logic              rst,
    exe_muldiv_unit_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic             start, div_zero, last;
    logic [WIDTH-1:0] op_a, op_b, acc;
    logic [3:0]       cmd;
    logic [4:0]       dest_q;
    logic             wb_q;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] a_nxt, b_nxt, acc_nxt, iter_res;
    logic [WIDTH:0]   trial;

    always_comb begin
        start    = bus.in_valid && !bus.flush && (state == IDLE) &&
                   (bus.EXE_cmd inside {CMD_MUL, CMD_DIV, CMD_REM});
        div_zero = (bus.EXE_cmd != CMD_MUL) && (bus.Val2 == '0);
        last     = (count == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.stall     = 1'b0;
        bus.res_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.stall = start;
                if (start) state_nxt = div_zero ? DONE : BUSY;
            end
            BUSY: begin
                // Flush releases the stall in the same cycle so the redirected fetch is not held.
                bus.stall = !bus.flush;
                if (bus.flush)  state_nxt = IDLE;
                else if (last)  state_nxt = DONE;
            end
            DONE: begin
                bus.res_valid = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // op_a doubles as shifted multiplicand (MUL) or dividend/quotient shift register (DIV/REM);
    // acc is the running product or partial remainder.
    always_comb begin
        a_nxt   = op_a;
        b_nxt   = op_b;
        acc_nxt = acc;
        trial   = {acc, op_a[WIDTH-1]} - {1'b0, op_b};
        if (cmd == CMD_MUL) begin
            acc_nxt = op_b[0] ? acc + op_a : acc;
            a_nxt   = op_a << 1;
            b_nxt   = op_b >> 1;
        end else if (!trial[WIDTH]) begin
            acc_nxt = trial[WIDTH-1:0];
            a_nxt   = {op_a[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = {acc[WIDTH-2:0], op_a[WIDTH-1]};
            a_nxt   = {op_a[WIDTH-2:0], 1'b0};
        end
        iter_res = (cmd == CMD_DIV) ? a_nxt : acc_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a          <= '0;
            op_b          <= '0;
            acc           <= '0;
            cmd           <= '0;
            dest_q        <= '0;
            wb_q          <= 1'b0;
            count         <= '0;
            bus.res       <= '0;
            bus.res_dest  <= '0;
            bus.res_WB_en <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a   <= bus.Val1;
                        op_b   <= bus.Val2;
                        acc    <= '0;
                        cmd    <= bus.EXE_cmd;
                        dest_q <= bus.dest;
                        wb_q   <= bus.WB_en;
                        count  <= '0;
                        if (div_zero) begin
                            bus.res       <= (bus.EXE_cmd == CMD_DIV) ? '1 : bus.Val1;
                            bus.res_dest  <= bus.dest;
                            bus.res_WB_en <= bus.WB_en;
                        end
                    end
                end
                BUSY: begin
                    if (!bus.flush) begin
                        op_a  <= a_nxt;
                        op_b  <= b_nxt;
                        acc   <= acc_nxt;
                        count <= count + CNT_W'(1);
                        if (last) begin
                            bus.res       <= iter_res;
                            bus.res_dest  <= dest_q;
                            bus.res_WB_en <= wb_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Randomized and directed checks of exe_muldiv_unit against a plain-arithmetic reference model.
module tb_exe_muldiv_unit;
    localparam int unsigned WIDTH = 32;
    localparam logic [3:0] MUL = 4'b1100;
    localparam logic [3:0] DIV = 4'b1101;
    localparam logic [3:0] REM = 4'b1110;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    exe_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

    exe_muldiv_unit #(
        .WIDTH  (WIDTH),
        .CMD_MUL(MUL),
        .CMD_DIV(DIV),
        .CMD_REM(REM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [3:0] c, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        if (c == MUL)      return p[31:0];
        else if (b == 0)   return (c == DIV) ? 32'hFFFF_FFFF : a;
        else if (c == DIV) return a / b;
        else               return a % b;
    endfunction

    // Issues one op starting right after a rising edge and follows it until the result pulse.
    task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic wb);
        int exp_lat, n, stall_cnt;
        bit got;
        exp_lat = (c != MUL && b == 0) ? 1 : WIDTH + 1;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.EXE_cmd  = c;
        bus.Val1     = a;
        bus.Val2     = b;
        bus.dest     = d;
        bus.WB_en    = wb;
        @(negedge clk);
        check("start_stall", 64'(bus.stall), 64'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 1; got = 0; stall_cnt = 1;
        while (n <= 40 && !got) begin
            @(negedge clk);
            if (bus.res_valid) begin
                got = 1;
                check("latency", 64'(n), 64'(exp_lat));
                check("res", 64'(bus.res), 64'(ref_result(c, a, b)));
                check("res_dest", 64'(bus.res_dest), 64'(d));
                check("res_WB_en", 64'(bus.res_WB_en), 64'(wb));
                check("done_stall", 64'(bus.stall), 64'(0));
            end else if (bus.stall) begin
                stall_cnt++;
            end
            n++;
        end
        if (!got) check("result_timeout", 64'(0), 64'(1));
        check("stall_cycles", 64'(stall_cnt), 64'(exp_lat));
        @(negedge clk);
        check("pulse_width", 64'(bus.res_valid), 64'(0));
    endtask

    initial begin
        int pulses, p1, p2, k;
        logic [3:0]  c;
        logic [31:0] a, b;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.EXE_cmd  = '0;
        bus.Val1     = '0;
        bus.Val2     = '0;
        bus.dest     = '0;
        bus.WB_en    = 1'b0;
        bus.flush    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stall", 64'(bus.stall), 64'(0));
        check("rst_res_valid", 64'(bus.res_valid), 64'(0));
        check("rst_res", 64'(bus.res), 64'(0));
        check("rst_res_dest", 64'(bus.res_dest), 64'(0));
        check("rst_res_WB_en", 64'(bus.res_WB_en), 64'(0));
        rst = 1'b0;

        do_op(MUL, 32'd7, 32'd6, 5'd3, 1'b1);
        do_op(MUL, 32'hFFFF_FFFF, 32'd2, 5'd4, 1'b1);
        do_op(DIV, 32'd100, 32'd7, 5'd5, 1'b1);
        do_op(REM, 32'd100, 32'd7, 5'd6, 1'b0);
        do_op(DIV, 32'd5, 32'd0, 5'd7, 1'b1);
        do_op(REM, 32'd5, 32'd0, 5'd8, 1'b1);
        do_op(DIV, 32'hFFFF_FFFF, 32'd1, 5'd9, 1'b1);
        do_op(REM, 32'h8000_0001, 32'hFFFF_FFFF, 5'd10, 1'b1);

        // Flush while BUSY at count==10
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.EXE_cmd = MUL; bus.Val1 = 32'd11; bus.Val2 = 32'd13;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(negedge clk);
        check("flush_stall", 64'(bus.stall), 64'(0));
        @(posedge clk); #1;
        bus.flush = 1'b0;
        pulses = 0; k = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.res_valid) pulses++;
            if (bus.stall) k++;
        end
        check("flush_no_pulse", 64'(pulses), 64'(0));
        check("flush_no_stall", 64'(k), 64'(0));
        do_op(MUL, 32'd3, 32'd3, 5'd11, 1'b1);

        // Non-muldiv command is ignored
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.EXE_cmd = 4'b0000; bus.Val1 = 32'd9; bus.Val2 = 32'd0;
        pulses = 0; k = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.res_valid) pulses++;
            if (bus.stall) k++;
        end
        check("other_cmd_stall", 64'(k), 64'(0));
        check("other_cmd_pulse", 64'(pulses), 64'(0));

        // Flush beats a start-eligible request in IDLE
        @(posedge clk); #1;
        bus.EXE_cmd = DIV; bus.Val1 = 32'd50; bus.Val2 = 32'd5; bus.flush = 1'b1;
        @(negedge clk);
        check("flush_idle_stall", 64'(bus.stall), 64'(0));
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.res_valid) pulses++;
        end
        check("flush_idle_pulse", 64'(pulses), 64'(0));

        // Flush in DONE still lets the result issue
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.EXE_cmd = MUL; bus.Val1 = 32'd1234; bus.Val2 = 32'd5678;
        bus.dest = 5'd21; bus.WB_en = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (32) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(negedge clk);
        check("flush_done_valid", 64'(bus.res_valid), 64'(1));
        check("flush_done_res", 64'(bus.res), 64'(ref_result(MUL, 32'd1234, 32'd5678)));
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_done_after", 64'(bus.res_valid), 64'(0));

        // Asynchronous reset in the middle of a divide
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.EXE_cmd = DIV; bus.Val1 = 32'd1000; bus.Val2 = 32'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_stall", 64'(bus.stall), 64'(0));
        check("mid_rst_valid", 64'(bus.res_valid), 64'(0));
        check("mid_rst_res", 64'(bus.res), 64'(0));
        check("mid_rst_dest", 64'(bus.res_dest), 64'(0));
        check("mid_rst_wb", 64'(bus.res_WB_en), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.res_valid) pulses++;
        end
        check("mid_rst_no_pulse", 64'(pulses), 64'(0));

        // Back-to-back MULs with in_valid held
        @(posedge clk); #1;
        a = $urandom; b = $urandom;
        bus.in_valid = 1'b1; bus.EXE_cmd = MUL; bus.Val1 = a; bus.Val2 = b;
        bus.dest = 5'd30; bus.WB_en = 1'b1;
        p1 = -1; p2 = -1;
        for (int cyc = 0; cyc < 100 && p2 < 0; cyc++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                check("b2b_res", 64'(bus.res), 64'(ref_result(MUL, a, b)));
                if (p1 < 0) p1 = cyc;
                else        p2 = cyc;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("b2b_first", 64'(p1), 64'(WIDTH + 1));
        check("b2b_gap", 64'(p2 - p1), 64'(WIDTH + 2));

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0:       c = MUL;
                1:       c = DIV;
                default: c = REM;
            endcase
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = a;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            do_op(c, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
